// File: rtl/decryption_round.sv
// decryption_round: one registered AES-128 inverse-cipher middle round.
// The output is InvSubBytes(InvShiftRows(InvMixColumns(data ^ key))).
// Optional macro DEC_ROUND_FINAL_EN adds a final_round input. When final_round
// is set, InvMixColumns is skipped, which undoes encryption round 10.
module decryption_round (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  input  logic [127:0] key,
`ifdef DEC_ROUND_FINAL_EN
  input  logic         final_round,
`endif
  input  logic [127:0] data,
  output logic         out_valid,
  output logic [127:0] decRound
);

  localparam int unsigned NB = 4;   // columns in the state
  localparam int unsigned NR = 4;   // rows in the state

  logic         r_out_valid;
  logic [127:0] r_dec_round;
  logic [127:0] w_add;
  logic [127:0] w_mix;
  logic [127:0] w_pre;
  logic [127:0] w_out;

  // Multiply by x in GF(2^8) mod 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (= product of x^(2^k), k=1..7); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] acc;
    logic [7:0] sq;
    acc = 8'h01;
    sq  = x;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Inverse S-box: undo the affine transform, then invert in the field.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  // InvMixColumns on one column; row 0 is in the top byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // Combinational round: AddRoundKey, InvMixColumns, InvShiftRows, InvSubBytes.
  always_comb begin
    w_add = data ^ key;
    w_mix = '0;
    w_out = '0;
    for (int c = 0; c < NB; c++) begin
      w_mix[127-32*c -: 32] = inv_mix_col(w_add[127-32*c -: 32]);
    end
`ifdef DEC_ROUND_FINAL_EN
    w_pre = final_round ? w_add : w_mix;
`else
    w_pre = w_mix;
`endif
    // Byte i sits at row i%4, column i/4; row r rotates right by r columns.
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < NR; r++) begin
        w_out[127-8*(4*c+r) -: 8] =
          inv_sbox(w_pre[127-8*(4*((c - r + 4) % 4) + r) -: 8]);
      end
    end
  end

  // Output register: capture on in_valid, hold when idle, clear on reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_out_valid <= 1'b0;
      r_dec_round <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) r_dec_round <= w_out;
    end
  end

  assign out_valid = r_out_valid;
  assign decRound  = r_dec_round;

endmodule

// File: tb/tb_decryption_round.sv
// tb_decryption_round: directed checks of the registered AES inverse round.
// It also covers the final_round bypass when DEC_ROUND_FINAL_EN is defined.
module tb_decryption_round;

  localparam logic [127:0] KNOWN_KEY  = 128'hE232FCF191129188B159E4E6D679A293;
  localparam logic [127:0] KNOWN_DATA = 128'h5847088B15B61CBA59D4E2E8CD39DFCE;
  localparam logic [127:0] KNOWN_EXP  = 128'h001F0E543C4E08596E221B0B4774311A;
  localparam logic [127:0] ZERO_VEC   = 128'h0123456789ABCDEF0011223344556677;
  localparam logic [127:0] ZERO_EXP   = 128'h52525252525252525252525252525252;
  localparam logic [127:0] CONST_DATA = 128'h63636363636363636363636363636363;

  logic         clk;
  logic         n_rst;
  logic         in_valid;
  logic [127:0] key;
  logic [127:0] data;
  logic         final_round;
  logic         out_valid;
  logic [127:0] decRound;

  int checks;
  int errors;

  decryption_round dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .key       (key),
`ifdef DEC_ROUND_FINAL_EN
    .final_round(final_round),
`endif
    .data      (data),
    .out_valid (out_valid),
    .decRound  (decRound)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs on the falling edge, then sample 1 ns after the next rising edge.
  task automatic drive_cycle(input logic rst_n_v, input logic vld, input logic [127:0] k,
                             input logic [127:0] d, input logic fin);
    @(negedge clk);
    n_rst       = rst_n_v;
    in_valid    = vld;
    key         = k;
    data        = d;
    final_round = fin;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 1'b1, KNOWN_KEY, KNOWN_DATA, 1'b0);
      checks++;
      if (decRound !== 128'h0) begin
        errors++;
        $display("FAIL reset_data cycle %0d: got %h want %h", i, decRound, 128'h0);
      end
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_valid cycle %0d: got %b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_known_vector;
    drive_cycle(1'b1, 1'b1, KNOWN_KEY, KNOWN_DATA, 1'b0);
    checks++;
    if (decRound !== KNOWN_EXP) begin
      errors++;
      $display("FAIL known_data: got %h want %h", decRound, KNOWN_EXP);
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL known_valid: got %b want 1", out_valid);
    end
    drive_cycle(1'b1, 1'b0, ZERO_VEC, CONST_DATA, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid: got %b want 0", out_valid);
    end
    checks++;
    if (decRound !== KNOWN_EXP) begin
      errors++;
      $display("FAIL idle_hold: got %h want %h", decRound, KNOWN_EXP);
    end
  endtask

  task automatic test_zero_state;
    drive_cycle(1'b1, 1'b1, ZERO_VEC, ZERO_VEC, 1'b0);
    checks++;
    if (decRound !== ZERO_EXP) begin
      errors++;
      $display("FAIL zero_state_data: got %h want %h", decRound, ZERO_EXP);
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL zero_state_valid: got %b want 1", out_valid);
    end
  endtask

  task automatic test_const_column;
    drive_cycle(1'b1, 1'b1, 128'h0, CONST_DATA, 1'b0);
    checks++;
    if (decRound !== 128'h0) begin
      errors++;
      $display("FAIL const_column_data: got %h want %h", decRound, 128'h0);
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL const_column_valid: got %b want 1", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    drive_cycle(1'b1, 1'b1, KNOWN_KEY, KNOWN_DATA, 1'b0);
    checks++;
    if (decRound !== KNOWN_EXP || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got %h/%b want %h/1", decRound, out_valid, KNOWN_EXP);
    end
    drive_cycle(1'b1, 1'b1, ZERO_VEC, ZERO_VEC, 1'b0);
    checks++;
    if (decRound !== ZERO_EXP || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: got %h/%b want %h/1", decRound, out_valid, ZERO_EXP);
    end
    drive_cycle(1'b1, 1'b0, 128'h0, 128'h0, 1'b0);
    checks++;
    if (decRound !== ZERO_EXP || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got %h/%b want %h/0", decRound, out_valid, ZERO_EXP);
    end
  endtask

  task automatic test_reset_mid;
    drive_cycle(1'b1, 1'b1, KNOWN_KEY, KNOWN_DATA, 1'b0);
    checks++;
    if (decRound !== KNOWN_EXP || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_first: got %h/%b want %h/1", decRound, out_valid, KNOWN_EXP);
    end
    drive_cycle(1'b0, 1'b1, ZERO_VEC, ZERO_VEC, 1'b0);
    checks++;
    if (decRound !== 128'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got %h/%b want 0/0", decRound, out_valid);
    end
    drive_cycle(1'b1, 1'b0, ZERO_VEC, ZERO_VEC, 1'b0);
    checks++;
    if (decRound !== 128'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_lost: got %h/%b want 0/0", decRound, out_valid);
    end
  endtask

`ifdef DEC_ROUND_FINAL_EN
  task automatic test_final_round;
    logic [127:0] fin_res;
    drive_cycle(1'b1, 1'b1, 128'h0, CONST_DATA, 1'b1);
    checks++;
    if (decRound !== 128'h0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL final_const: got %h/%b want 0/1", decRound, out_valid);
    end
    drive_cycle(1'b1, 1'b1, KNOWN_KEY, KNOWN_DATA, 1'b1);
    fin_res = decRound;
    drive_cycle(1'b1, 1'b1, KNOWN_KEY, KNOWN_DATA, 1'b0);
    checks++;
    if (decRound !== KNOWN_EXP) begin
      errors++;
      $display("FAIL final_off_known: got %h want %h", decRound, KNOWN_EXP);
    end
    checks++;
    if (fin_res === decRound) begin
      errors++;
      $display("FAIL final_differs: got %h for both, want different results", fin_res);
    end
  endtask
`endif

  initial begin
    checks      = 0;
    errors      = 0;
    n_rst       = 1'b0;
    in_valid    = 1'b0;
    key         = '0;
    data        = '0;
    final_round = 1'b0;
    test_reset();
    test_known_vector();
    test_zero_state();
    test_const_column();
    test_back_to_back();
    test_reset_mid();
`ifdef DEC_ROUND_FINAL_EN
    test_final_round();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decryption_round.md
Name: decryption_round

Overview:
- One standard AES-128 inverse-cipher round, registered.
- Takes a 128-bit state and its 128-bit round key. Applies AddRoundKey, InvMixColumns, InvShiftRows and InvSubBytes, in that order. This is the exact inverse of encryption round r (SubBytes, ShiftRows, MixColumns, AddRoundKey).
- Instantiated by the decryption datapath, once per middle round (rounds 9..1), with the round-key schedule supplying `key`.

Parameters:
- None. Fixed 128-bit state and key.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- n_rst  input  1  synchronous active-low reset.
- in_valid  input  1  qualifies `data` and `key` this cycle.
- key  input  128  round key for this round (same round index as the encryption round being undone).
- data  input  128  input state (ciphertext-side state).
- out_valid  output  1  `decRound` holds a new result.
- decRound  output  128  resulting state (plaintext-side state).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (`clk`, `n_rst`).
- Reset: when `n_rst`=0 at a rising edge, `decRound` becomes 128'h0 and `out_valid` becomes 0. Reset overrides `in_valid` in the same cycle. A result in flight during reset is discarded.
- Byte mapping: byte i = data[127-8i -: 8], for i = 0..15. The state is column-major: byte i sits at row i%4, column i/4. The key uses the same mapping.
- Step 1, AddRoundKey: s = data XOR key.
- Step 2, InvMixColumns: applied per column with the GF(2^8) matrix rows [0e 0b 0d 09], [09 0e 0b 0d], [0d 09 0e 0b], [0b 0d 09 0e]. Reduction polynomial is x^8+x^4+x^3+x+1 (0x11B).
- Step 3, InvShiftRows: row r is rotated right by r columns, i.e. new[r][c] = old[r][(c-r) mod 4].
- Step 4, InvSubBytes: the FIPS-197 inverse S-box on every byte, e.g. 00->52, 63->00, 52->00? no: inv(52)=48, 16->ff.
- Datapath: the whole transform is combinational between the input ports and the output register.
- Latency: exactly 1 cycle.
  - If `in_valid`=1 at edge N, then after edge N `decRound` holds the transform of the `data`/`key` sampled at edge N, and `out_valid`=1.
- Idle cycles: if `in_valid`=0 at an edge, `out_valid` goes to 0 and `decRound` keeps its previous value.
- Throughput: back-to-back `in_valid` is allowed, with one result per cycle and no stall and no ready signal.
- The output must not change except on a rising edge.

Optional Feature:
- Macro: DEC_ROUND_FINAL_EN.
- When defined: an extra input port `final_round` (1 bit) is added after `key`.
  - When `final_round`=1 on an accepted input, InvMixColumns is bypassed and the output is InvSubBytes(InvShiftRows(data XOR key)). This undoes encryption round 10.
  - When `final_round`=0, the normal round is performed.
  - `final_round` is sampled with `in_valid`.
- When not defined: no `final_round` port, and InvMixColumns is always applied.

Test Plan:
- Reset: hold `n_rst`=0 with `in_valid`=1 and arbitrary data for 2 cycles -> `decRound`=0, `out_valid`=0.
- Known vector: key=128'hE232FCF191129188B159E4E6D679A293, data=128'h5847088B15B61CBA59D4E2E8CD39DFCE, `in_valid`=1 for one cycle -> next cycle `decRound`=128'h001F0E543C4E08596E221B0B4774311A, `out_valid`=1. The cycle after, with `in_valid`=0 -> `out_valid`=0 and `decRound` unchanged.
- Zero-state vector: data=key=128'h0123456789ABCDEF0011223344556677 -> `decRound`=128'h52525252525252525252525252525252.
- Constant-column vector: key=0, data=128'h63636363636363636363636363636363 -> `decRound`=0, since InvMixColumns of a constant column is the identity.
- Streaming and reset mid-operation:
  - Apply the known vector and the zero-state vector on consecutive cycles -> their results appear on consecutive cycles, in order.
  - Assert `n_rst`=0 on the edge that would capture the second result -> outputs are 0 and that result is lost.
- With DEC_ROUND_FINAL_EN:
  - `final_round`=1, key=0, data=128'h63636363636363636363636363636363 -> 0.
  - `final_round`=1 and `final_round`=0 on the known vector -> the two results differ.
